// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the scratchpad memory bus responder.
package mem_bus_pkg;

  localparam int DEF_ADDR_WIDTH    = 8;
  localparam int DEF_DATABUS_WIDTH = 32;
  localparam int DEF_DEPTH         = 256;
  localparam int DEF_LATENCY       = 2;
  localparam int DEF_CNT_WIDTH     = 16;

  // Released bus value; the top replicates bit 0 to its own data width.
  localparam logic [DEF_DATABUS_WIDTH-1:0] HIZ_DATA = {DEF_DATABUS_WIDTH{1'bz}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2,
    RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/mem_bus_ram.sv
// Single-clock word array with a bus write/read port and a host write/read
// port. Both writes land on the same edge; the bus write is issued last so it
// wins on an address collision. Out-of-range addresses never write and read 0.
module mem_bus_ram
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATABUS_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  bus_we,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic [DATA_WIDTH-1:0] bus_wdata,
  output logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] host_rdata
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  bus_ok;
  logic                  host_ok;

  assign bus_ok  = {1'b0, bus_addr} < DEPTH_W;
  assign host_ok = {1'b0, host_addr} < DEPTH_W;

  // Write ports: host first, bus second so the bus has priority.
  always_ff @(posedge clk) begin
    if (host_we && host_ok) mem[host_addr] <= host_wdata;
    if (bus_we && bus_ok)   mem[bus_addr]  <= bus_wdata;
  end

  assign bus_rdata  = bus_ok  ? mem[bus_addr]  : '0;
  assign host_rdata = host_ok ? mem[host_addr] : '0;

endmodule

// File: rtl/mem_bus_responder.sv
// Scratchpad responder on the engines' tri-state memory bus.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | waiting for mem_sel; request fields latched on acceptance
//   BUSY    | latency down-counter running; mem_sel low aborts the request
//   RESPOND | one-cycle ready (and err); read data driven onto data_bus
//   RELEASE | waiting for mem_sel low so a held strobe is not served twice
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int DATABUS_WIDTH = DEF_DATABUS_WIDTH,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int LATENCY       = DEF_LATENCY,
  parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_sel,
  input  logic                     mem_w,
  input  logic [ADDR_WIDTH-1:0]    address_bus,
  inout  wire  [DATABUS_WIDTH-1:0] data_bus,
  output logic                     ready,
  output logic                     err,
  input  logic                     host_we,
  input  logic [ADDR_WIDTH-1:0]    host_addr,
  input  logic [DATABUS_WIDTH-1:0] host_wdata,
  output logic [DATABUS_WIDTH-1:0] host_rdata,
  output logic [CNT_WIDTH-1:0]     rd_count,
  output logic [CNT_WIDTH-1:0]     wr_count
);

  localparam int                     CW       = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0]          CNT_INIT = CW'(LATENCY - 1);
  localparam logic [ADDR_WIDTH:0]    DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [DATABUS_WIDTH-1:0] HIZ    = {DATABUS_WIDTH{HIZ_DATA[0]}};

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     accept, commit;
  logic [ADDR_WIDTH-1:0]    req_addr_q;
  logic                     req_w_q;
  logic [DATABUS_WIDTH-1:0] req_data_q;
  logic [DATABUS_WIDTH-1:0] rd_reg_q;
  logic                     ready_q, err_q;

  // With LATENCY=1 the commit happens on the accept edge itself, so the
  // commit fields come straight from the bus in IDLE, else from the latches.
  logic [ADDR_WIDTH-1:0]    c_addr;
  logic                     c_w;
  logic [DATABUS_WIDTH-1:0] c_data;
  logic                     c_ok;
  logic [DATABUS_WIDTH-1:0] ram_bus_rdata;
  logic [DATABUS_WIDTH-1:0] ram_host_rdata;

  assign c_addr = (state_q == IDLE) ? address_bus : req_addr_q;
  assign c_w    = (state_q == IDLE) ? mem_w       : req_w_q;
  assign c_data = (state_q == IDLE) ? data_bus    : req_data_q;
  assign c_ok   = {1'b0, c_addr} < DEPTH_W;

  // Next-state decode; commit marks the edge that enters RESPOND.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_sel) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_d = RESPOND;
            commit  = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (!mem_sel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(1)) begin
          state_d = RESPOND;
          commit  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESPOND: state_d = RELEASE;
      RELEASE: if (!mem_sel) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latency counter and latched request fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_addr_q <= '0;
      req_w_q    <= 1'b0;
      req_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        req_addr_q <= address_bus;
        req_w_q    <= mem_w;
        req_data_q <= data_bus;
      end
    end
  end

  // Response registers loaded on the RESPOND entry edge, cleared the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      rd_reg_q <= '0;
    end else begin
      ready_q <= commit;
      err_q   <= commit & ~c_ok;
      if (commit && !c_w) rd_reg_q <= ram_bus_rdata;
    end
  end

  // Completion counters, saturating; errored transfers still count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state_q == RESPOND) begin
      if (req_w_q) begin
        if (wr_count != '1) wr_count <= wr_count + 1'b1;
      end else begin
        if (rd_count != '1) rd_count <= rd_count + 1'b1;
      end
    end
  end

  // Registered host read-back; shows pre-write data on a same-edge write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) host_rdata <= '0;
    else     host_rdata <= ram_host_rdata;
  end

  // The write strobe is gated by rst so a request held across reset cannot commit.
  mem_bus_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATABUS_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk        (clk),
    .bus_we     (commit & c_w & c_ok & ~rst),
    .bus_addr   (c_addr),
    .bus_wdata  (c_data),
    .bus_rdata  (ram_bus_rdata),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (ram_host_rdata)
  );

  assign ready    = ready_q;
  assign err      = err_q;
  assign data_bus = (state_q == RESPOND && !req_w_q) ? rd_reg_q : HIZ;

endmodule
